// File: rtl/multi_issue_control_unit_pkg.sv
// Shared decode constants, FSM state and per-lane control bundle for the
// multi-issue ID-stage control unit.
package ctrl_pkg;

  // RV32I major opcodes recognised by the lane decoders
  localparam logic [6:0] ALU_R  = 7'b0110011;
  localparam logic [6:0] ALU_I  = 7'b0010011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JUMP   = 7'b1101111;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;

  // Branch func3 encodings resolved in ID
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  // ALUOp codes handed to the EX-stage ALU control
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    SQUASH = 1'b1
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [1:0] alu_op;
    logic       alu_src;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_2_reg;
    logic       is_branch;
    logic       is_jump;
  } lane_ctrl_t;

  // A bubble: nothing enabled, ALUOp parked on R-type
  function automatic lane_ctrl_t nop_ctrl();
    lane_ctrl_t c;
    c        = '0;
    c.alu_op = ALUOP_RTYPE;
    return c;
  endfunction

endpackage

// File: rtl/multi_issue_control_unit_if.sv
// Handshake/control bundle between the ID stage and the control unit.
// master = the side driving instructions in, slave = the control unit.
interface multi_issue_control_unit_if #(
  parameter int ISSUE = 2,
  parameter int CNT_W = 16
);
  logic               adv;
  logic [ISSUE-1:0]   valid_in;
  logic [7*ISSUE-1:0] opcode_in;
  logic [3*ISSUE-1:0] func3_in;
  logic               pred_taken;
  logic               reg_equal;
  logic [ISSUE-1:0]   valid_out;
  logic [2*ISSUE-1:0] alu_op;
  logic [ISSUE-1:0]   alu_src;
  logic [ISSUE-1:0]   reg_write;
  logic               mem_read;
  logic               mem_write;
  logic               mem_2_reg;
  logic               branch;
  logic               jump;
  logic               flush;
  logic [CNT_W-1:0]   mispredict_cnt;
  logic [CNT_W-1:0]   jump_cnt;

  modport master (
    output adv, valid_in, opcode_in, func3_in, pred_taken, reg_equal,
    input  valid_out, alu_op, alu_src, reg_write, mem_read, mem_write,
           mem_2_reg, branch, jump, flush, mispredict_cnt, jump_cnt
  );

  modport slave (
    input  adv, valid_in, opcode_in, func3_in, pred_taken, reg_equal,
    output valid_out, alu_op, alu_src, reg_write, mem_read, mem_write,
           mem_2_reg, branch, jump, flush, mispredict_cnt, jump_cnt
  );
endinterface

// File: rtl/multi_issue_control_unit_lane_decoder.sv
// Combinational single-lane decoder. FULL=1 decodes the whole RV32I subset
// (lane 0); FULL=0 accepts only ALU opcodes and turns anything else into a NOP.
module ctrl_lane_decoder
  import ctrl_pkg::*;
#(
  parameter int FULL = 1
) (
  input  logic       i_valid,
  input  logic [6:0] i_opcode,
  output lane_ctrl_t o_ctrl
);

  // Map the opcode to control bits; invalid or unsupported slots become bubbles.
  always_comb begin
    o_ctrl = nop_ctrl();
    if (i_valid) begin
      case (i_opcode)
        ALU_R: begin
          o_ctrl.valid     = 1'b1;
          o_ctrl.alu_op    = ALUOP_RTYPE;
          o_ctrl.reg_write = 1'b1;
        end
        ALU_I: begin
          o_ctrl.valid     = 1'b1;
          o_ctrl.alu_op    = ALUOP_ADD;
          o_ctrl.alu_src   = 1'b1;
          o_ctrl.reg_write = 1'b1;
        end
        LOAD: begin
          if (FULL != 0) begin
            o_ctrl.valid     = 1'b1;
            o_ctrl.alu_op    = ALUOP_ADD;
            o_ctrl.alu_src   = 1'b1;
            o_ctrl.reg_write = 1'b1;
            o_ctrl.mem_read  = 1'b1;
            o_ctrl.mem_2_reg = 1'b1;
          end else begin
            o_ctrl = nop_ctrl();
          end
        end
        STORE: begin
          if (FULL != 0) begin
            o_ctrl.valid     = 1'b1;
            o_ctrl.alu_op    = ALUOP_ADD;
            o_ctrl.alu_src   = 1'b1;
            o_ctrl.mem_write = 1'b1;
          end else begin
            o_ctrl = nop_ctrl();
          end
        end
        BRANCH: begin
          if (FULL != 0) begin
            o_ctrl.valid     = 1'b1;
            o_ctrl.alu_op    = ALUOP_SUB;
            o_ctrl.is_branch = 1'b1;
          end else begin
            o_ctrl = nop_ctrl();
          end
        end
        JUMP: begin
          if (FULL != 0) begin
            o_ctrl.valid     = 1'b1;
            o_ctrl.alu_op    = ALUOP_ADD;
            o_ctrl.reg_write = 1'b1;
            o_ctrl.is_jump   = 1'b1;
          end else begin
            o_ctrl = nop_ctrl();
          end
        end
        default: o_ctrl = nop_ctrl();
      endcase
    end else begin
      o_ctrl = nop_ctrl();
    end
  end

endmodule

// File: rtl/multi_issue_control_unit.sv
// N-issue ID-stage control unit: per-lane decode, lane-0 branch resolution,
// redirect squashing of younger bundles, registered ID/EX control outputs.
// Optional feature macro: CTRL_PERF_CNT_EN (mispredict / JAL-redirect counters).
module multi_issue_control_unit
  import ctrl_pkg::*;
#(
  parameter int ISSUE        = 2,
  parameter int SQUASH_DEPTH = 1,
  parameter int CNT_W        = 16
) (
  input  logic                        clk,
  input  logic                        arst,
  multi_issue_control_unit_if.slave   bus
);

  localparam int SQ_W = $clog2(SQUASH_DEPTH + 1);

  lane_ctrl_t       w_dec  [ISSUE];
  lane_ctrl_t       w_lane [ISSUE];
  state_t           r_state, w_state_nxt;
  logic [SQ_W-1:0]  r_sq_cnt, w_sq_cnt_nxt;
  logic             w_mispredict, w_jal, w_redirect;
  logic             w_unused_func3;

  logic [ISSUE-1:0]   r_valid_out, r_alu_src, r_reg_write;
  logic [2*ISSUE-1:0] r_alu_op;
  logic               r_mem_read, r_mem_write, r_mem_2_reg;
  logic               r_branch, r_jump, r_flush;

  // Only lane 0 carries a branch, so the other func3 fields are don't-care.
  assign w_unused_func3 = ^bus.func3_in;

  for (genvar g = 0; g < ISSUE; g++) begin : g_lane
    ctrl_lane_decoder #(.FULL(g == 0 ? 1 : 0)) u_dec (
      .i_valid  (bus.valid_in[g]),
      .i_opcode (bus.opcode_in[7*g +: 7]),
      .o_ctrl   (w_dec[g])
    );
  end

  // Resolve lane-0 control flow; wrong-path bundles in SQUASH never redirect.
  always_comb begin
    w_mispredict = 1'b0;
    w_jal        = 1'b0;
    if (r_state == RUN) begin
      if (w_dec[0].is_branch) begin
        case (bus.func3_in[2:0])
          F3_BEQ:  w_mispredict = (bus.reg_equal != bus.pred_taken);
          F3_BNE:  w_mispredict = (bus.reg_equal == bus.pred_taken);
          default: w_mispredict = 1'b0;
        endcase
      end else begin
        w_mispredict = 1'b0;
      end
      w_jal = w_dec[0].is_jump;
    end else begin
      w_mispredict = 1'b0;
      w_jal        = 1'b0;
    end
  end

  assign w_redirect = w_mispredict | w_jal;

  // Next FSM state/squash count, and lane controls after wrong-path masking.
  always_comb begin
    w_state_nxt  = r_state;
    w_sq_cnt_nxt = r_sq_cnt;
    for (int i = 0; i < ISSUE; i++) w_lane[i] = w_dec[i];
    case (r_state)
      RUN: begin
        if (w_redirect) begin
          w_state_nxt  = SQUASH;
          w_sq_cnt_nxt = SQ_W'(SQUASH_DEPTH);
          for (int i = 1; i < ISSUE; i++) w_lane[i] = nop_ctrl();
        end else begin
          w_state_nxt = RUN;
        end
      end
      SQUASH: begin
        for (int i = 0; i < ISSUE; i++) w_lane[i] = nop_ctrl();
        if (r_sq_cnt <= SQ_W'(1)) begin
          w_state_nxt  = RUN;
          w_sq_cnt_nxt = '0;
        end else begin
          w_sq_cnt_nxt = r_sq_cnt - SQ_W'(1);
        end
      end
      default: begin
        w_state_nxt  = RUN;
        w_sq_cnt_nxt = '0;
        for (int i = 0; i < ISSUE; i++) w_lane[i] = nop_ctrl();
      end
    endcase
  end

  // FSM and squash counter move only when the pipeline advances.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state  <= RUN;
      r_sq_cnt <= '0;
    end else if (bus.adv) begin
      r_state  <= w_state_nxt;
      r_sq_cnt <= w_sq_cnt_nxt;
    end
  end

  // ID/EX control registers; flush drops during stalls so a redirect pulses once.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_valid_out <= '0;
      r_alu_op    <= '0;
      r_alu_src   <= '0;
      r_reg_write <= '0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_2_reg <= 1'b0;
      r_branch    <= 1'b0;
      r_jump      <= 1'b0;
      r_flush     <= 1'b0;
    end else if (bus.adv) begin
      for (int i = 0; i < ISSUE; i++) begin
        r_valid_out[i]     <= w_lane[i].valid;
        r_alu_op[2*i +: 2] <= w_lane[i].alu_op;
        r_alu_src[i]       <= w_lane[i].alu_src;
        r_reg_write[i]     <= w_lane[i].reg_write;
      end
      r_mem_read  <= w_lane[0].mem_read;
      r_mem_write <= w_lane[0].mem_write;
      r_mem_2_reg <= w_lane[0].mem_2_reg;
      r_branch    <= w_mispredict;
      r_jump      <= w_jal;
      r_flush     <= w_redirect;
    end else begin
      r_flush <= 1'b0;
    end
  end

  assign bus.valid_out = r_valid_out;
  assign bus.alu_op    = r_alu_op;
  assign bus.alu_src   = r_alu_src;
  assign bus.reg_write = r_reg_write;
  assign bus.mem_read  = r_mem_read;
  assign bus.mem_write = r_mem_write;
  assign bus.mem_2_reg = r_mem_2_reg;
  assign bus.branch    = r_branch;
  assign bus.jump      = r_jump;
  assign bus.flush     = r_flush;

`ifdef CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] r_mis_cnt, r_jmp_cnt;

  // Saturating event counters, stepped only on advancing RUN-state edges.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_mis_cnt <= '0;
      r_jmp_cnt <= '0;
    end else if (bus.adv) begin
      if (w_mispredict && (r_mis_cnt != {CNT_W{1'b1}})) r_mis_cnt <= r_mis_cnt + CNT_W'(1);
      if (w_jal && (r_jmp_cnt != {CNT_W{1'b1}}))        r_jmp_cnt <= r_jmp_cnt + CNT_W'(1);
    end
  end

  assign bus.mispredict_cnt = r_mis_cnt;
  assign bus.jump_cnt       = r_jmp_cnt;
`else
  assign bus.mispredict_cnt = '0;
  assign bus.jump_cnt       = '0;
`endif

endmodule

// File: tb/tb_multi_issue_control_unit.sv
// Self-checking bench: two instances (SQUASH_DEPTH 1 and 3) share one stimulus
// stream and are compared against a behavioural model of the decode rules.
module tb_multi_issue_control_unit;
  import ctrl_pkg::*;

`ifdef CTRL_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic arst;
  always #5 clk = ~clk;

  logic        in_adv, in_pt, in_re;
  logic [1:0]  in_valid;
  logic [13:0] in_opc;
  logic [5:0]  in_f3;

  multi_issue_control_unit_if #(.ISSUE(2), .CNT_W(16)) bus0 ();
  multi_issue_control_unit_if #(.ISSUE(2), .CNT_W(16)) bus1 ();

  assign bus0.adv = in_adv;  assign bus0.valid_in = in_valid; assign bus0.opcode_in = in_opc;
  assign bus0.func3_in = in_f3; assign bus0.pred_taken = in_pt; assign bus0.reg_equal = in_re;
  assign bus1.adv = in_adv;  assign bus1.valid_in = in_valid; assign bus1.opcode_in = in_opc;
  assign bus1.func3_in = in_f3; assign bus1.pred_taken = in_pt; assign bus1.reg_equal = in_re;

  multi_issue_control_unit #(.ISSUE(2), .SQUASH_DEPTH(1), .CNT_W(16)) dut0 (
    .clk(clk), .arst(arst), .bus(bus0.slave));
  multi_issue_control_unit #(.ISSUE(2), .SQUASH_DEPTH(3), .CNT_W(16)) dut1 (
    .clk(clk), .arst(arst), .bus(bus1.slave));

  int checks = 0;
  int errors = 0;

  // Model state per instance
  logic [15:0] exp_o   [2];
  int          sq_left [2];
  int          exp_mis [2];
  int          exp_jmp [2];
  int          depth   [2] = '{1, 3};

  // Packed view: {valid_out, alu_op, alu_src, reg_write, mem_read, mem_write, mem_2_reg, branch, jump, flush}
  function automatic logic [15:0] obs(input int d);
    if (d == 0)
      return {bus0.valid_out, bus0.alu_op, bus0.alu_src, bus0.reg_write, bus0.mem_read,
              bus0.mem_write, bus0.mem_2_reg, bus0.branch, bus0.jump, bus0.flush};
    return {bus1.valid_out, bus1.alu_op, bus1.alu_src, bus1.reg_write, bus1.mem_read,
            bus1.mem_write, bus1.mem_2_reg, bus1.branch, bus1.jump, bus1.flush};
  endfunction

  function automatic logic [15:0] obs_mis(input int d);
    return (d == 0) ? bus0.mispredict_cnt : bus1.mispredict_cnt;
  endfunction

  function automatic logic [15:0] obs_jmp(input int d);
    return (d == 0) ? bus0.jump_cnt : bus1.jump_cnt;
  endfunction

  // Lane behaviour: {valid, aluop[1:0], src, rw, mr, mw, m2r, br, jal}
  function automatic logic [9:0] ref_lane(input logic v, input logic [6:0] op, input bit full);
    logic [9:0] nop;
    nop = 10'b0_10_0_0_0_0_0_0_0;
    if (!v)                  return nop;
    if (op == 7'h33)         return 10'b1_10_0_1_0_0_0_0_0;
    if (op == 7'h13)         return 10'b1_00_1_1_0_0_0_0_0;
    if (!full)               return nop;
    if (op == 7'h03)         return 10'b1_00_1_1_1_0_1_0_0;
    if (op == 7'h23)         return 10'b1_00_1_0_0_1_0_0_0;
    if (op == 7'h63)         return 10'b1_01_0_0_0_0_0_1_0;
    if (op == 7'h6F)         return 10'b1_00_0_1_0_0_0_0_1;
    return nop;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      exp_o[d] = 16'h0000; sq_left[d] = 0; exp_mis[d] = 0; exp_jmp[d] = 0;
    end
  endtask

  task automatic model_edge(input int d);
    logic [9:0] l0, l1;
    logic mis, jal;
    if (arst) begin
      exp_o[d] = 16'h0000; sq_left[d] = 0; exp_mis[d] = 0; exp_jmp[d] = 0;
      return;
    end
    if (!in_adv) begin
      exp_o[d][0] = 1'b0;
      return;
    end
    if (sq_left[d] > 0) begin
      sq_left[d] = sq_left[d] - 1;
      exp_o[d] = {2'b00, 4'b1010, 2'b00, 2'b00, 6'b000000};
      return;
    end
    l0  = ref_lane(in_valid[0], in_opc[6:0], 1'b1);
    l1  = ref_lane(in_valid[1], in_opc[13:7], 1'b0);
    mis = l0[1] && (((in_f3[2:0] == 3'd0) && (in_re != in_pt)) ||
                    ((in_f3[2:0] == 3'd1) && (in_re == in_pt)));
    jal = l0[0];
    if (mis || jal) begin
      l1 = 10'b0_10_0_0_0_0_0_0_0;
      sq_left[d] = depth[d];
      if (mis) exp_mis[d] = exp_mis[d] + 1;
      if (jal) exp_jmp[d] = exp_jmp[d] + 1;
    end
    exp_o[d] = {l1[9], l0[9], l1[8:7], l0[8:7], l1[6], l0[6], l1[5], l0[5],
                l0[4], l0[3], l0[2], mis, jal, mis | jal};
  endtask

  task automatic step(input logic adv);
    in_adv = adv;
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
  endtask

  task automatic set_bundle(input logic [1:0] v, input logic [6:0] op0, input logic [6:0] op1,
                            input logic [2:0] f3, input logic pt, input logic re);
    in_valid = v; in_opc = {op1, op0}; in_f3 = {3'b000, f3}; in_pt = pt; in_re = re;
  endtask

  task automatic idle(input int n);
    set_bundle(2'b00, 7'h00, 7'h00, 3'b000, 1'b0, 1'b0);
    for (int k = 0; k < n; k++) step(1'b1);
  endtask

  task automatic test_reset();
    arst = 1'b1;
    set_bundle(2'b11, 7'h33, 7'h13, 3'b000, 1'b0, 1'b0);
    in_adv = 1'b1;
    #1;
    model_reset();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obs(d) !== 16'h0000 || obs_mis(d) !== 16'h0000 || obs_jmp(d) !== 16'h0000) begin
        errors++;
        $display("FAIL reset_outputs dut%0d: got %h/%h/%h want 0", d, obs(d), obs_mis(d), obs_jmp(d));
      end
    end
    step(1'b1);
    step(1'b1);
    arst = 1'b0;
  endtask

  task automatic test_alu_pair();
    idle(4);
    set_bundle(2'b11, 7'h33, 7'h13, 3'b000, 1'b0, 1'b0);
    step(1'b1);
    checks++;
    if (bus0.valid_out !== 2'b11 || bus0.reg_write !== 2'b11 || bus0.alu_op !== 4'b0010 ||
        bus0.alu_src !== 2'b10 || bus0.flush !== 1'b0) begin
      errors++;
      $display("FAIL alu_pair: got v=%b rw=%b op=%b src=%b fl=%b want 11 11 0010 10 0",
               bus0.valid_out, bus0.reg_write, bus0.alu_op, bus0.alu_src, bus0.flush);
    end
    checks++;
    if (obs(1) !== exp_o[1]) begin
      errors++;
      $display("FAIL alu_pair_dut1: got %h want %h", obs(1), exp_o[1]);
    end
  endtask

  task automatic test_mispredict();
    idle(4);
    set_bundle(2'b11, 7'h63, 7'h13, 3'b000, 1'b0, 1'b1);
    step(1'b1);
    checks++;
    if (bus0.flush !== 1'b1 || bus0.branch !== 1'b1 || bus0.valid_out !== 2'b01) begin
      errors++;
      $display("FAIL mispredict_redirect: got fl=%b br=%b v=%b want 1 1 01",
               bus0.flush, bus0.branch, bus0.valid_out);
    end
    checks++;
    if (bus0.mispredict_cnt !== (PERF ? 16'(exp_mis[0]) : 16'h0000)) begin
      errors++;
      $display("FAIL mispredict_cnt: got %0d want %0d", bus0.mispredict_cnt, PERF ? exp_mis[0] : 0);
    end
    set_bundle(2'b11, 7'h33, 7'h13, 3'b000, 1'b0, 1'b0);
    step(1'b1);
    checks++;
    if (bus0.valid_out !== 2'b00 || bus0.flush !== 1'b0) begin
      errors++;
      $display("FAIL mispredict_squash: got v=%b fl=%b want 00 0", bus0.valid_out, bus0.flush);
    end
    step(1'b1);
    checks++;
    if (bus0.valid_out !== 2'b11) begin
      errors++;
      $display("FAIL mispredict_resume: got v=%b want 11", bus0.valid_out);
    end
    checks++;
    if (obs(1) !== exp_o[1]) begin
      errors++;
      $display("FAIL mispredict_dut1: got %h want %h", obs(1), exp_o[1]);
    end
  endtask

  task automatic test_correct_bne();
    idle(4);
    set_bundle(2'b11, 7'h63, 7'h33, 3'b001, 1'b1, 1'b0);
    step(1'b1);
    checks++;
    if (bus0.flush !== 1'b0 || bus0.branch !== 1'b0 || bus0.alu_op[1:0] !== 2'b01 ||
        bus0.valid_out !== 2'b11) begin
      errors++;
      $display("FAIL correct_bne: got fl=%b br=%b op0=%b v=%b want 0 0 01 11",
               bus0.flush, bus0.branch, bus0.alu_op[1:0], bus0.valid_out);
    end
    checks++;
    if (bus0.mispredict_cnt !== (PERF ? 16'(exp_mis[0]) : 16'h0000)) begin
      errors++;
      $display("FAIL correct_bne_cnt: got %0d want %0d", bus0.mispredict_cnt, PERF ? exp_mis[0] : 0);
    end
  endtask

  task automatic test_jal_stall();
    logic [15:0] snap;
    idle(4);
    snap = obs(0);
    set_bundle(2'b11, 7'h6F, 7'h33, 3'b000, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(1'b0);
      checks++;
      if (obs(0) !== exp_o[0] || exp_o[0] !== snap) begin
        errors++;
        $display("FAIL jal_stall_hold cyc%0d: got %h want %h", k, obs(0), exp_o[0]);
      end
    end
    step(1'b1);
    checks++;
    if (bus0.flush !== 1'b1 || bus0.jump !== 1'b1 || bus0.reg_write[0] !== 1'b1 ||
        bus0.valid_out !== 2'b01) begin
      errors++;
      $display("FAIL jal_redirect: got fl=%b j=%b rw0=%b v=%b want 1 1 1 01",
               bus0.flush, bus0.jump, bus0.reg_write[0], bus0.valid_out);
    end
    checks++;
    if (bus0.jump_cnt !== (PERF ? 16'd1 : 16'd0)) begin
      errors++;
      $display("FAIL jal_cnt: got %0d want %0d", bus0.jump_cnt, PERF ? 1 : 0);
    end
    step(1'b0);
    checks++;
    if (bus0.flush !== 1'b0 || bus0.jump !== 1'b1) begin
      errors++;
      $display("FAIL jal_single_pulse: got fl=%b j=%b want 0 1", bus0.flush, bus0.jump);
    end
  endtask

  task automatic test_reset_mid_squash();
    idle(4);
    set_bundle(2'b11, 7'h63, 7'h33, 3'b000, 1'b1, 1'b0);
    step(1'b1);
    set_bundle(2'b11, 7'h33, 7'h13, 3'b000, 1'b0, 1'b0);
    step(1'b1);
    checks++;
    if (bus1.valid_out !== 2'b00) begin
      errors++;
      $display("FAIL midsq_squashed: got v=%b want 00", bus1.valid_out);
    end
    arst = 1'b1;
    #1;
    model_reset();
    checks++;
    if (obs(1) !== 16'h0000 || obs(0) !== 16'h0000) begin
      errors++;
      $display("FAIL midsq_async_reset: got %h/%h want 0000", obs(0), obs(1));
    end
    step(1'b1);
    arst = 1'b0;
    step(1'b1);
    checks++;
    if (bus1.valid_out !== 2'b11 || bus1.alu_op !== 4'b0010) begin
      errors++;
      $display("FAIL midsq_after_release: got v=%b op=%b want 11 0010", bus1.valid_out, bus1.alu_op);
    end
  endtask

  task automatic test_illegal_slot();
    idle(4);
    set_bundle(2'b11, 7'h7F, 7'h03, 3'b000, 1'b0, 1'b0);
    step(1'b1);
    checks++;
    if (bus0.valid_out !== 2'b00 || bus0.mem_read !== 1'b0 || bus0.alu_op !== 4'b1010 ||
        bus0.reg_write !== 2'b00) begin
      errors++;
      $display("FAIL illegal_slot: got v=%b mr=%b op=%b rw=%b want 00 0 1010 00",
               bus0.valid_out, bus0.mem_read, bus0.alu_op, bus0.reg_write);
    end
  endtask

  task automatic test_random();
    logic [6:0] ops [6] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F};
    logic [6:0] op0, op1;
    int p;
    for (int n = 0; n < 400; n++) begin
      p   = $urandom_range(0, 6);
      op0 = (p == 6) ? 7'($urandom) : ops[p];
      p   = $urandom_range(0, 6);
      op1 = (p == 6) ? 7'($urandom) : ops[p];
      set_bundle(2'($urandom), op0, op1, 3'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
      arst = ($urandom_range(0, 63) == 0);
      step($urandom_range(0, 3) != 0);
      arst = 1'b0;
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs(d) !== exp_o[d]) begin
          errors++;
          $display("FAIL random_ctrl dut%0d iter%0d: got %h want %h", d, n, obs(d), exp_o[d]);
        end
        checks++;
        if (obs_mis(d) !== (PERF ? 16'(exp_mis[d]) : 16'h0000) ||
            obs_jmp(d) !== (PERF ? 16'(exp_jmp[d]) : 16'h0000)) begin
          errors++;
          $display("FAIL random_cnt dut%0d iter%0d: got %0d/%0d want %0d/%0d", d, n,
                   obs_mis(d), obs_jmp(d), PERF ? exp_mis[d] : 0, PERF ? exp_jmp[d] : 0);
        end
      end
    end
  endtask

  initial begin
    arst = 1'b0;
    in_adv = 1'b0;
    set_bundle(2'b00, 7'h00, 7'h00, 3'b000, 1'b0, 1'b0);
    #2;
    test_reset();
    test_alu_pair();
    test_mispredict();
    test_correct_bne();
    test_jal_stall();
    test_reset_mid_squash();
    test_illegal_slot();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
